timing_mode_ctrl: RTL and testbench

TIMING_MODE_CTRL -- requirements
Module: timing_mode_ctrl

---
 rtl/timing_pkg.sv | 48 ++++
 rtl/timing_mode_rom.sv | 11 +
 rtl/timing_mode_ctrl.sv | 142 ++++++++++++++
 tb/tb_timing_mode_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/timing_pkg.sv
// Shared widths, FSM state encoding and the video mode table for the timing mode controller.
// Pure declarations plus one combinational lookup helper; no clocked logic here.
package timing_pkg;

    localparam int MODE_W    = 2;
    localparam int NUM_MODES = 4;
    localparam int HV_W      = 16;
    localparam int PORCH_W   = 8;
    localparam int WDOG_W    = 24;
    localparam int QCNT_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    typedef struct packed {
        logic [HV_W-1:0]    hactive;
        logic [PORCH_W-1:0] hfp;
        logic [PORCH_W-1:0] hsw;
        logic [PORCH_W-1:0] hbp;
        logic [HV_W-1:0]    vactive;
        logic [PORCH_W-1:0] vfp;
        logic [PORCH_W-1:0] vsw;
        logic [PORCH_W-1:0] vbp;
        logic               hpol;
    } mode_params_t;

    localparam int PARAMS_W = $bits(mode_params_t);

    function automatic mode_params_t mode_lookup(input logic [MODE_W-1:0] idx);
        mode_params_t p;
        case (idx)
            2'd0: p = '{hactive: 16'd800,  hfp: 8'd40,  hsw: 8'd128, hbp: 8'd88,
                        vactive: 16'd480,  vfp: 8'd1,   vsw: 8'd4,   vbp: 8'd23, hpol: 1'b0};
            2'd1: p = '{hactive: 16'd640,  hfp: 8'd16,  hsw: 8'd96,  hbp: 8'd48,
                        vactive: 16'd480,  vfp: 8'd10,  vsw: 8'd2,   vbp: 8'd33, hpol: 1'b0};
            2'd2: p = '{hactive: 16'd1280, hfp: 8'd110, hsw: 8'd40,  hbp: 8'd220,
                        vactive: 16'd720,  vfp: 8'd5,   vsw: 8'd5,   vbp: 8'd20, hpol: 1'b1};
            default: p = '{hactive: 16'd1024, hfp: 8'd24, hsw: 8'd136, hbp: 8'd160,
                        vactive: 16'd768,  vfp: 8'd3,   vsw: 8'd6,   vbp: 8'd29, hpol: 1'b0};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/timing_mode_rom.sv
// Combinational mode index -> parameter set lookup; zero latency, no flow control.
module timing_mode_rom
    import timing_pkg::*;
(
    input  logic [MODE_W-1:0]   mode_idx,
    output logic [PARAMS_W-1:0] params
);

    assign params = mode_lookup(mode_idx);

endmodule

// File: rtl/timing_mode_ctrl.sv
// Mode switch sequencer: drains to a vsync boundary, holds the sync generator off for
// QUIET_CYCLES, reloads timing parameters; all outputs registered, requests accepted only in IDLE/RUN.
module timing_mode_ctrl
    import timing_pkg::*;
#(
    parameter int QUIET_CYCLES   = 16,
    parameter int START_MODE     = 0,
    parameter bit VS_ACTIVE_HIGH = 1'b0,
    parameter int WDOG_CYCLES    = 4000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_i,
    input  logic [1:0]  mode_sel_i,
    input  logic        mode_req_i,
    input  logic        vsync_i,
    output logic        sync_en_o,
    output logic        hpol_o,
    output logic [15:0] hactive_o,
    output logic [15:0] vactive_o,
    output logic [7:0]  hfp_o,
    output logic [7:0]  hbp_o,
    output logic [7:0]  hsw_o,
    output logic [7:0]  vfp_o,
    output logic [7:0]  vbp_o,
    output logic [7:0]  vsw_o,
    output logic [1:0]  mode_o,
    output logic        ready_o,
    output logic        ack_o,
    output logic        wdog_o
);

    localparam logic [MODE_W-1:0] START_IDX  = MODE_W'(START_MODE);
    localparam logic [QCNT_W-1:0] QUIET_LAST = QCNT_W'(QUIET_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);

    state_t              state;
    logic [MODE_W-1:0]   pending;
    logic [QCNT_W-1:0]   qcnt;
    logic [WDOG_W-1:0]   wcnt;
    logic                vs_prev;
    mode_params_t        params_q;

    logic                vs_act;
    logic                vs_edge;
    logic [MODE_W-1:0]   rom_idx;
    logic [PARAMS_W-1:0] rom_vec;
    mode_params_t        rom_params;

    assign vs_act  = (vsync_i == VS_ACTIVE_HIGH);
    assign vs_edge = vs_act && !vs_prev;

    // An IDLE request loads straight from the selector; every other load comes from pending.
    assign rom_idx    = (state == ST_IDLE && mode_req_i) ? mode_sel_i : pending;
    assign rom_params = mode_params_t'(rom_vec);

    timing_mode_rom u_rom (
        .mode_idx (rom_idx),
        .params   (rom_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sync_en_o <= 1'b0;
            ack_o     <= 1'b0;
            wdog_o    <= 1'b0;
            ready_o   <= 1'b1;
            mode_o    <= START_IDX;
            pending   <= START_IDX;
            params_q  <= mode_lookup(START_IDX);
            qcnt      <= '0;
            wcnt      <= '0;
            vs_prev   <= 1'b0;
        end else begin
            ack_o     <= 1'b0;
            vs_prev   <= vs_act;
            sync_en_o <= (state == ST_RUN) || (state == ST_DRAIN);
            case (state)
                ST_IDLE: begin
                    if (mode_req_i || enable_i) begin
                        pending  <= rom_idx;
                        mode_o   <= rom_idx;
                        params_q <= rom_params;
                    end
                    if (mode_req_i) begin
                        ack_o <= 1'b1;
                    end
                    if (enable_i) begin
                        state   <= ST_QUIET;
                        ready_o <= 1'b0;
                        qcnt    <= '0;
                    end
                end
                ST_RUN: begin
                    if (mode_req_i) begin
                        pending <= mode_sel_i;
                    end
                    if (mode_req_i || !enable_i) begin
                        state   <= ST_DRAIN;
                        ready_o <= 1'b0;
                        wcnt    <= '0;
                    end
                end
                ST_DRAIN: begin
                    // A real frame boundary wins over a coincident watchdog expiry.
                    if (vs_edge || wcnt == WDOG_LAST) begin
                        if (!vs_edge) begin
                            wdog_o <= 1'b1;
                        end
                        state    <= ST_QUIET;
                        qcnt     <= '0;
                        mode_o   <= pending;
                        params_q <= rom_params;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ST_QUIET: begin
                    if (qcnt == QUIET_LAST) begin
                        state   <= enable_i ? ST_RUN : ST_IDLE;
                        ready_o <= 1'b1;
                        ack_o   <= 1'b1;
                    end else begin
                        qcnt <= qcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign hactive_o = params_q.hactive;
    assign hfp_o     = params_q.hfp;
    assign hsw_o     = params_q.hsw;
    assign hbp_o     = params_q.hbp;
    assign vactive_o = params_q.vactive;
    assign vfp_o     = params_q.vfp;
    assign vsw_o     = params_q.vsw;
    assign vbp_o     = params_q.vbp;
    assign hpol_o    = params_q.hpol;

endmodule

// File: tb/tb_timing_mode_ctrl.sv
// Directed bench for timing_mode_ctrl: enable, mode switch, dropped requests, watchdog, reset.
module tb_timing_mode_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic [1:0]  mode_sel_i;
    logic        mode_req_i;
    logic        vsync_i;
    logic        sync_en_o;
    logic        hpol_o;
    logic [15:0] hactive_o;
    logic [15:0] vactive_o;
    logic [7:0]  hfp_o, hbp_o, hsw_o, vfp_o, vbp_o, vsw_o;
    logic [1:0]  mode_o;
    logic        ready_o;
    logic        ack_o;
    logic        wdog_o;

    int checks   = 0;
    int failures = 0;
    int acks     = 0;
    int cnt;
    int sync_hi;

    always #5 clk = ~clk;

    timing_mode_ctrl #(
        .QUIET_CYCLES   (16),
        .START_MODE     (0),
        .VS_ACTIVE_HIGH (1'b0),
        .WDOG_CYCLES    (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (enable_i),
        .mode_sel_i (mode_sel_i),
        .mode_req_i (mode_req_i),
        .vsync_i    (vsync_i),
        .sync_en_o  (sync_en_o),
        .hpol_o     (hpol_o),
        .hactive_o  (hactive_o),
        .vactive_o  (vactive_o),
        .hfp_o      (hfp_o),
        .hbp_o      (hbp_o),
        .hsw_o      (hsw_o),
        .vfp_o      (vfp_o),
        .vbp_o      (vbp_o),
        .vsw_o      (vsw_o),
        .mode_o     (mode_o),
        .ready_o    (ready_o),
        .ack_o      (ack_o),
        .wdog_o     (wdog_o)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_o) acks++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; enable_i = 1'b0; mode_sel_i = 2'd0; mode_req_i = 1'b0; vsync_i = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", ready_o, 1);
        chk("rst_sync_en", sync_en_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_wdog", wdog_o, 0);
        chk("rst_mode", mode_o, 0);
        chk("rst_hactive", hactive_o, 800);
        chk("rst_vactive", vactive_o, 480);
        chk("rst_hfp", hfp_o, 40);
        chk("rst_hpol", hpol_o, 0);

        // Enable from IDLE: QUIET then RUN, sync_en rises 17 cycles after the sampling edge.
        enable_i = 1'b1;
        tick();
        acks = 0;
        cnt = 0;
        do begin tick(); cnt++; end while (!sync_en_o && cnt < 40);
        chk("en_rise_latency", cnt, 17);
        chk("en_ack_count", acks, 1);
        chk("en_ready", ready_o, 1);
        chk("en_mode", mode_o, 0);
        chk("en_hactive", hactive_o, 800);

        // Mode switch to 2 from RUN; a request during DRAIN must be dropped.
        mode_sel_i = 2'd2; mode_req_i = 1'b1;
        acks = 0;
        tick();
        mode_req_i = 1'b0;
        chk("drain_ready", ready_o, 0);
        chk("drain_sync_en", sync_en_o, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin mode_sel_i = 2'd3; mode_req_i = 1'b1; end
            else mode_req_i = 1'b0;
            tick();
        end
        mode_req_i = 1'b0;
        chk("drain_sync_hold", sync_en_o, 1);
        chk("drain_mode_hold", mode_o, 0);
        chk("drain_hactive_hold", hactive_o, 800);
        vsync_i = 1'b0;
        tick();
        vsync_i = 1'b1;
        chk("quiet_entry_mode", mode_o, 2);
        chk("quiet_entry_hactive", hactive_o, 1280);
        chk("quiet_entry_vactive", vactive_o, 720);
        chk("quiet_entry_hbp", hbp_o, 220);
        chk("quiet_entry_hpol", hpol_o, 1);
        tick();
        chk("quiet_sync_low", sync_en_o, 0);
        cnt = 1;
        while (!sync_en_o && cnt < 40) begin
            if (cnt == 4) begin mode_sel_i = 2'd3; mode_req_i = 1'b1; end
            else mode_req_i = 1'b0;
            if (cnt == 6) enable_i = 1'b0;
            if (cnt == 9) enable_i = 1'b1;
            tick();
            if (!sync_en_o) cnt++;
        end
        mode_req_i = 1'b0;
        chk("quiet_low_cycles", cnt, 16);
        chk("switch_ack_count", acks, 1);
        chk("switch_mode_kept", mode_o, 2);
        chk("switch_hfp_kept", hfp_o, 110);
        chk("switch_ready", ready_o, 1);

        // Watchdog: vsync never active during DRAIN.
        mode_sel_i = 2'd3; mode_req_i = 1'b1;
        tick();
        mode_req_i = 1'b0;
        chk("wdog_pre", wdog_o, 0);
        cnt = 0;
        do begin tick(); cnt++; end while (!wdog_o && cnt < 300);
        chk("wdog_drain_cycles", cnt, 100);
        chk("wdog_sync_en_last", sync_en_o, 1);
        chk("wdog_mode", mode_o, 3);
        chk("wdog_hactive", hactive_o, 1024);
        chk("wdog_hsw", hsw_o, 136);
        tick();
        chk("wdog_quiet_sync", sync_en_o, 0);
        acks = 0;
        cnt = 0;
        do begin tick(); cnt++; end while (!sync_en_o && cnt < 60);
        chk("wdog_reenable_cycles", cnt, 16);
        chk("wdog_sticky", wdog_o, 1);
        chk("wdog_ack_count", acks, 1);

        // Disable and request mode 1 in the same cycle: drain, quiet, idle.
        enable_i = 1'b0; mode_sel_i = 2'd1; mode_req_i = 1'b1;
        tick();
        mode_req_i = 1'b0;
        vsync_i = 1'b0;
        tick();
        vsync_i = 1'b1;
        chk("dis_mode", mode_o, 1);
        chk("dis_hactive", hactive_o, 640);
        chk("dis_vbp", vbp_o, 33);
        chk("dis_vfp", vfp_o, 10);
        acks = 0;
        sync_hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sync_en_o) sync_hi++;
        end
        chk("dis_sync_high_cycles", sync_hi, 0);
        chk("dis_ready", ready_o, 1);
        chk("dis_ack_count", acks, 1);
        chk("dis_mode_final", mode_o, 1);

        // IDLE request: loads next cycle with ack the same cycle.
        mode_sel_i = 2'd2; mode_req_i = 1'b1;
        tick();
        mode_req_i = 1'b0;
        chk("idle_req_mode", mode_o, 2);
        chk("idle_req_hactive", hactive_o, 1280);
        chk("idle_req_ack", ack_o, 1);
        chk("idle_req_sync_en", sync_en_o, 0);
        tick();
        chk("idle_req_ack_pulse", ack_o, 0);
        chk("idle_req_ready", ready_o, 1);

        // Request mode 3 plus enable, then reset mid-QUIET.
        mode_sel_i = 2'd3; mode_req_i = 1'b1; enable_i = 1'b1;
        tick();
        mode_req_i = 1'b0;
        chk("q3_mode", mode_o, 3);
        chk("q3_ack", ack_o, 1);
        repeat (5) tick();
        chk("q3_ready", ready_o, 0);
        chk("q3_sync_en", sync_en_o, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0; enable_i = 1'b0;
        chk("midrst_ready", ready_o, 1);
        chk("midrst_mode", mode_o, 0);
        chk("midrst_hactive", hactive_o, 800);
        chk("midrst_sync_en", sync_en_o, 0);
        chk("midrst_wdog", wdog_o, 0);
        chk("midrst_ack", ack_o, 0);
        repeat (20) tick();
        chk("midrst_idle_ready", ready_o, 1);
        chk("midrst_idle_sync", sync_en_o, 0);

        // Re-enable after reset: quiet counter restarts from zero.
        enable_i = 1'b1;
        tick();
        cnt = 0;
        do begin tick(); cnt++; end while (!sync_en_o && cnt < 40);
        chk("post_rst_rise_latency", cnt, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
